// File: rtl/chisq_units_merge_fsm_pkg.sv
// chisq_units_merge_fsm_pkg: selector encodings shared with the round-robin distributor
package chisq_units_merge_fsm_pkg;
    localparam int NUM_UNITS = 3;
    typedef enum logic [1:0] {SEL1 = 2'b00, SEL2 = 2'b01, SEL3 = 2'b10} sel_state_t;
    function automatic sel_state_t next_sel(input sel_state_t s);
        return s == SEL1 ? SEL2 : s == SEL2 ? SEL3 : SEL1;
    endfunction
endpackage

// File: rtl/chisq_units_merge_fsm_if.sv
// chisq_units_merge_fsm_if: per-unit result inputs and merged output stream
interface chisq_units_merge_fsm_if #(parameter int W = 32);
    import chisq_units_merge_fsm_pkg::*;
    logic [NUM_UNITS-1:0]   res_valid;
    logic [NUM_UNITS*W-1:0] res_data;
    logic [NUM_UNITS-1:0]   res_ev;
    logic [NUM_UNITS-1:0]   almost_full;
    logic [W-1:0]           out_data;
    logic                   out_ev;
    logic                   out_valid;
    logic                   out_ready;
    logic [1:0]             sel_unit_out;
    logic [NUM_UNITS-1:0]   ovf;
    modport master (
        output res_valid, res_data, res_ev, out_ready,
        input  almost_full, out_data, out_ev, out_valid, sel_unit_out, ovf
    );
    modport slave (
        input  res_valid, res_data, res_ev, out_ready,
        output almost_full, out_data, out_ev, out_valid, sel_unit_out, ovf
    );
endinterface

// File: rtl/chisq_res_fifo.sv
// chisq_res_fifo: per-unit result FIFO; writes to a full FIFO are dropped, a word written while empty pops next cycle
module chisq_res_fifo #(
    parameter int WIDTH     = 33,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 12
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       almost_full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_CNT   = (AW+1)'(AF_THRESH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_wr, do_rd;
    logic [AW:0]      count_nxt;
    always_comb begin
        full      = count == FULL_CNT;
        empty     = count == '0;
        do_wr     = wr_en && !full;
        do_rd     = rd_en && !empty;
        count_nxt = count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        rd_data   = mem[rd_ptr];
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            almost_full <= 1'b0;
        end else begin
            wr_ptr      <= do_wr ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr      <= do_rd ? rd_ptr + AW'(1) : rd_ptr;
            count       <= count_nxt;
            almost_full <= count_nxt >= AF_CNT;
        end
    end
    always_ff @(posedge clock) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/chisq_units_merge_fsm.sv
// chisq_units_merge_fsm: re-serialises three units' result streams in round-robin event order
module chisq_units_merge_fsm
    import chisq_units_merge_fsm_pkg::*;
#(
    parameter int W         = 32,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 12
) (
    input logic                    clock,
    input logic                    reset,
    chisq_units_merge_fsm_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    sel_state_t           state;
    logic [1:0]           cur;
    logic [NUM_UNITS-1:0] full, empty, pop, ovf_q;
    logic [W:0]           head [NUM_UNITS];
    logic [AW:0]          count [NUM_UNITS];
    logic [W:0]           head_sel;
    logic                 do_pop, out_valid_q, out_ev_q;
    logic [W-1:0]         out_data_q;
    assign cur      = state;
    assign head_sel = cur == 2'd1 ? head[1] : cur == 2'd2 ? head[2] : head[0];
    assign do_pop   = |pop;
    for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
        assign pop[u] = cur == 2'(u) && !empty[u] && (!out_valid_q || bus.out_ready);
        chisq_res_fifo #(.WIDTH(W + 1), .DEPTH(DEPTH), .AF_THRESH(AF_THRESH)) u_fifo (
            .clock      (clock),
            .reset      (reset),
            .wr_en      (bus.res_valid[u]),
            .wr_data    ({bus.res_ev[u], bus.res_data[u*W +: W]}),
            .rd_en      (pop[u]),
            .rd_data    (head[u]),
            .full       (full[u]),
            .empty      (empty[u]),
            .count      (count[u]),
            .almost_full(bus.almost_full[u])
        );
        a_empty_count: assert property (@(posedge clock) disable iff (reset) empty[u] == (count[u] == '0));
    end
    // State only advances once the end-of-event word has been taken into the output register
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= SEL1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ev_q    <= 1'b0;
            ovf_q       <= '0;
        end else begin
            ovf_q       <= ovf_q | (bus.res_valid & full);
            out_valid_q <= do_pop ? 1'b1 : out_valid_q && !bus.out_ready;
            out_data_q  <= do_pop ? head_sel[W-1:0] : out_data_q;
            out_ev_q    <= do_pop ? head_sel[W] : out_ev_q;
            state       <= !(state inside {SEL1, SEL2, SEL3}) ? SEL1 :
                           (do_pop && head_sel[W]) ? next_sel(state) : state;
        end
    end
    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_ev       = out_ev_q;
    assign bus.sel_unit_out = cur;
    assign bus.ovf          = ovf_q;
endmodule

// File: doc/chisq_units_merge_fsm.md
Name: chisq_units_merge_fsm

Overview:
- Output-side counterpart of the chisq unit round-robin distributor.
- Events are dispatched to three chisq units in order 0→1→2→0. This block collects each unit's result words and re-serialises them onto one downstream stream in the same round-robin event order.
- Each unit gets a small FIFO, so units may finish with differing latency.
- A read-side selector FSM advances to the next unit only after the end-of-event word of the current unit has been forwarded.

Parameters:
- W, 32, result word width per unit.
- DEPTH, 16, per-unit FIFO depth in words; must be a power of two, at least 4.
- AF_THRESH, 12, per-unit FIFO occupancy at or above which almost_full is asserted.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- res_valid  in  3  per-unit result word strobe; bit u belongs to unit u.
- res_data  in  3*W  per-unit result words; unit u occupies bits [u*W +: W].
- res_ev  in  3  per-unit end-of-event flag, qualified by res_valid[u].
- almost_full  out  3  per-unit FIFO occupancy >= AF_THRESH; registered.
- out_data  out  W  merged result word.
- out_ev  out  1  end-of-event flag accompanying out_data.
- out_valid  out  1  out_data and out_ev are valid.
- out_ready  in  1  downstream accepts the word when out_valid && out_ready.
- sel_unit_out  out  2  unit currently being drained: 2'b00, 2'b01 or 2'b10.
- ovf  out  3  sticky per-unit overflow flag.

Behaviour:
- Reset values: every FIFO empty; sel_unit_out=2'b00; out_valid=0; out_data=0; out_ev=0; almost_full=0; ovf=0. Reset asserted mid-event discards all buffered and in-flight words, and the next event is read from unit 0.
- Write side, per unit u, every cycle: if res_valid[u] and count_u < DEPTH (count sampled before the edge), store {res_ev[u], res_data[u]} and increment count. If the FIFO is full, drop the word and set ovf[u]=1 until reset. A simultaneous pop does not rescue a write to a full FIFO.
- Read-side FSM states: SEL1 (2'b00), SEL2 (2'b01), SEL3 (2'b10).
  - Any other encoding goes to SEL1 on the next edge.
  - sel_unit_out equals the state.
- Pop condition: FIFO[state] non-empty and (!out_valid || out_ready).
- On a pop:
  - the head word loads into the output register;
  - out_valid becomes 1;
  - if the popped word's ev flag is 1, the state advances SEL1→SEL2→SEL3→SEL1 on the same edge.
- If out_valid && out_ready and there is no pop, out_valid clears to 0.
- While out_valid && !out_ready, out_data and out_ev hold stable and no pop occurs.
- Latency: a word written at edge k can appear with out_valid=1 after edge k+1 at the earliest. Throughput is 1 word/cycle while out_ready=1 and the current FIFO is non-empty.
- Non-current units never stall the output. Their words accumulate until the selector reaches them.
- Simultaneous write and pop on the same FIFO in one cycle: both occur and count is unchanged. This includes an empty FIFO: a word written there is not poppable until the next cycle.
- Pointers are log2(DEPTH) bits wide and wrap naturally. count is log2(DEPTH)+1 bits wide.
- almost_full[u] is registered from the post-edge count.

Decomposition:
- Shared package holds:
  - state encodings SEL1/SEL2/SEL3, also used by the distributor FSM;
  - NUM_UNITS = 3.
- Sub-module chisq_res_fifo: synchronous FIFO of width W+1, with full, empty, count and almost_full outputs. It is instantiated three times.
- Top level holds the selector FSM, the output register and the overflow flags.

Test Plan:
- Reset, then unit 0 writes words A,B with ev=1 on B → out words A,B in consecutive cycles (out_ready=1), then sel_unit_out goes 0→1.
- Units write out of order: unit 2 {X, ev=1} at cycle 1, unit 1 {Y, ev=1} at cycle 3, unit 0 {Z, ev=1} at cycle 5 → output order Z,Y,X and sel_unit_out returns to 2'b00.
- Backpressure: out_ready=0 for 5 cycles while out_valid=1 → out_data held constant, no pops; out_ready=1 resumes at 1 word/cycle with no loss or duplication.
- Overflow: 17 writes to unit 1 while the selector sits on unit 0 (DEPTH=16) → ovf=3'b010, almost_full[1]=1 after the 12th write, and exactly 16 unit-1 words are later emitted.
- Reset asserted mid-event with 3 words buffered in unit 0 → out_valid=0 the next cycle, FIFOs empty, ovf cleared, and a fresh unit-0 event emits correctly.
- Random soak: 1000 events with random per-unit delays and out_ready at 50% → scoreboard order matches dispatch order exactly and ovf stays 0.
